// File: rtl/obi_axil_bridge.sv
// obi_axil_bridge
//   OBI-to-AXI4-Lite master bridge with up to MAX_OUTSTANDING transactions
//   in flight. A single issue register drives AR or AW/W. An order FIFO of
//   read/write flags selects which AXI response channel is accepted next, so
//   OBI responses come back in request order.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   obi_req_i/obi_gnt_o     OBI request handshake (gnt is combinational)
//   obi_addr_i/we_i/be_i/wdata_i  OBI request payload
//   obi_rvalid_o/rdata_o/err_o    OBI response, one cycle per transaction
//   aw_*, w_*, b_*          AXI4-Lite write channels
//   ar_*, r_*               AXI4-Lite read channels
module obi_axil_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Issue register
  logic                  iss_vld_q, iss_we_q, aw_done_q, w_done_q;
  logic [ADDR_WIDTH-1:0] iss_addr_q;
  logic [BE_W-1:0]       iss_be_q;
  logic [DATA_WIDTH-1:0] iss_wdata_q;

  // Order FIFO (1 = write) and outstanding counter
  logic [MAX_OUTSTANDING-1:0] ord_we_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           fifo_cnt_q, out_cnt_q;

  // Response register
  logic                  rvalid_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs, iss_done, accept, pop, fifo_empty, head_we;
  logic unused_resp;

  assign unused_resp = r_resp_i[0] ^ b_resp_i[0];

  assign ar_valid_o = iss_vld_q & ~iss_we_q;
  assign aw_valid_o = iss_vld_q & iss_we_q & ~aw_done_q;
  assign w_valid_o  = iss_vld_q & iss_we_q & ~w_done_q;
  assign ar_addr_o  = iss_addr_q;
  assign aw_addr_o  = iss_addr_q;
  assign w_data_o   = iss_wdata_q;
  assign w_strb_o   = iss_be_q;

  assign ar_hs = ar_valid_o & ar_ready_i;
  assign aw_hs = aw_valid_o & aw_ready_i;
  assign w_hs  = w_valid_o & w_ready_i;

  // A write completes once both AW and W have handshaken, in any order.
  assign iss_done = iss_vld_q &
                    (iss_we_q ? ((aw_done_q | aw_hs) & (w_done_q | w_hs)) : ar_hs);

  // The cycle a response is presented releases its slot, so it may grant.
  assign obi_gnt_o = obi_req_i & (~iss_vld_q | iss_done) &
                     ((out_cnt_q < CNT_W'(MAX_OUTSTANDING)) | rvalid_q);
  assign accept    = obi_gnt_o;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign head_we    = ord_we_q[rd_ptr_q];
  assign r_ready_o  = ~fifo_empty & ~head_we;
  assign b_ready_o  = ~fifo_empty & head_we;
  assign r_hs       = r_valid_i & r_ready_o;
  assign b_hs       = b_valid_i & b_ready_o;
  assign pop        = r_hs | b_hs;

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_vld_q   <= 1'b0;
      iss_we_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_be_q    <= '0;
      iss_wdata_q <= '0;
      ord_we_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      out_cnt_q   <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        iss_vld_q   <= 1'b1;
        iss_we_q    <= obi_we_i;
        iss_addr_q  <= obi_addr_i;
        iss_be_q    <= obi_be_i;
        iss_wdata_q <= obi_wdata_i;
        aw_done_q   <= 1'b0;
        w_done_q    <= 1'b0;
      end else if (iss_done) begin
        iss_vld_q <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end

      if (accept) begin
        ord_we_q[wr_ptr_q] <= obi_we_i;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({accept, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      case ({accept, rvalid_q})
        2'b10:   out_cnt_q <= out_cnt_q + CNT_W'(1);
        2'b01:   out_cnt_q <= out_cnt_q - CNT_W'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase

      rvalid_q <= pop;
      if (pop) begin
        rdata_q <= r_hs ? r_data_i : '0;
        err_q   <= r_hs ? r_resp_i[1] : b_resp_i[1];
      end else begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_obi_axil_bridge.sv
module tb_obi_axil_bridge;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            obi_req_i, obi_gnt_o, obi_we_i, obi_rvalid_o, obi_err_o;
  logic [AW-1:0]   obi_addr_i;
  logic [DW/8-1:0] obi_be_i;
  logic [DW-1:0]   obi_wdata_i, obi_rdata_o;
  logic            aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
  logic [AW-1:0]   aw_addr_o, ar_addr_o;
  logic [DW-1:0]   w_data_o, r_data_i;
  logic [DW/8-1:0] w_strb_o;
  logic            b_valid_i, b_ready_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
  logic [1:0]      b_resp_i, r_resp_i;

  obi_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  txn_t        mq[$];        // waiting to be requested
  txn_t        rsp_q[$];     // granted, awaiting AXI response, in OBI order
  logic [31:0] rd_iss_q[$];  // granted reads not yet through AR
  txn_t        aw_iss_q[$];
  txn_t        w_iss_q[$];
  int          outstanding = 0;
  logic        exp_rv = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        req_held = 1'b0;

  // AXI slave state
  logic [31:0] s_ar_q[$];
  logic [31:0] s_aw_q[$];
  int          s_w_cnt = 0;
  logic        r_hold = 1'b0, b_hold = 1'b0;
  logic [31:0] r_addr_cur = '0, b_addr_cur = '0;

  int req_pct = 100, ar_pct = 100, aw_pct = 100, w_pct = 100, r_pct = 100, b_pct = 100;

  // observation logs
  int          gnt_log[$], ar_log[$], aw_log[$], w_log[$], rv_log[$];
  logic [31:0] rvd_log[$];
  logic        rve_log[$];
  int          n_r_hs = 0, n_b_hs = 0;

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    if (a == 32'h0001_0004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    return a[13:12];
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete(); ar_log.delete(); aw_log.delete(); w_log.delete();
    rv_log.delete(); rvd_log.delete(); rve_log.delete();
  endtask

  // One clock: drive inputs, let combinational outputs settle, check against
  // the model, advance model and slave with the handshakes that will occur.
  task automatic cycle();
    logic have_r, free, exp_gnt, ar_hs, aw_hs, w_hs, r_hs, b_hs, g_hs, nxt_rv, nxt_err;
    logic [31:0] nxt_rdata;
    txn_t t;
    obi_req_i = 1'b0;
    if (mq.size() > 0 && (req_held || $urandom_range(99) < req_pct)) begin
      obi_req_i   = 1'b1;
      obi_we_i    = mq[0].we;
      obi_addr_i  = mq[0].addr;
      obi_be_i    = mq[0].be;
      obi_wdata_i = mq[0].wdata;
    end
    req_held   = obi_req_i;
    ar_ready_i = ($urandom_range(99) < ar_pct);
    aw_ready_i = ($urandom_range(99) < aw_pct);
    w_ready_i  = ($urandom_range(99) < w_pct);
    if (!r_hold) begin
      have_r = 1'b0;
      if (s_ar_q.size() > 0) begin
        have_r = 1'b1; r_addr_cur = s_ar_q[0];
      end else if (ar_valid_o && ar_ready_i) begin
        have_r = 1'b1; r_addr_cur = ar_addr_o;
      end
      r_valid_i = have_r && ($urandom_range(99) < r_pct);
    end
    r_data_i = rdata_fn(r_addr_cur);
    r_resp_i = resp_fn(r_addr_cur);
    if (!b_hold) begin
      b_valid_i = 1'b0;
      if (s_aw_q.size() > 0 && s_w_cnt > 0) begin
        b_addr_cur = s_aw_q[0];
        b_valid_i  = ($urandom_range(99) < b_pct);
      end
    end
    b_resp_i = resp_fn(b_addr_cur);
    #2;
    ar_hs = ar_valid_o & ar_ready_i;
    aw_hs = aw_valid_o & aw_ready_i;
    w_hs  = w_valid_o & w_ready_i;
    r_hs  = r_valid_i & r_ready_o;
    b_hs  = b_valid_i & b_ready_o;
    g_hs  = obi_req_i & obi_gnt_o;
    if (!rst) begin
      free = (rd_iss_q.size() == 0 || ar_ready_i) &&
             (aw_iss_q.size() == 0 || aw_ready_i) &&
             (w_iss_q.size() == 0 || w_ready_i);
      exp_gnt = obi_req_i && free && (outstanding < MAXO || exp_rv);
      chk("gnt", obi_gnt_o, exp_gnt);
      chk("ar_valid", ar_valid_o, rd_iss_q.size() > 0);
      if (rd_iss_q.size() > 0) chk("ar_addr", ar_addr_o, rd_iss_q[0]);
      chk("aw_valid", aw_valid_o, aw_iss_q.size() > 0);
      if (aw_iss_q.size() > 0) chk("aw_addr", aw_addr_o, aw_iss_q[0].addr);
      chk("w_valid", w_valid_o, w_iss_q.size() > 0);
      if (w_iss_q.size() > 0) begin
        chk("w_data", w_data_o, w_iss_q[0].wdata);
        chk("w_strb", w_strb_o, w_iss_q[0].be);
      end
      chk("r_ready", r_ready_o, rsp_q.size() > 0 && !rsp_q[0].we);
      chk("b_ready", b_ready_o, rsp_q.size() > 0 && rsp_q[0].we);
      chk("rvalid", obi_rvalid_o, exp_rv);
      if (exp_rv) begin
        chk("rdata", obi_rdata_o, exp_rdata);
        chk("err", obi_err_o, exp_err);
      end else begin
        chk("err_idle", obi_err_o, 1'b0);
      end
      // slave bookkeeping
      if (ar_hs) begin s_ar_q.push_back(ar_addr_o); ar_log.push_back(cyc); end
      if (aw_hs) begin s_aw_q.push_back(aw_addr_o); aw_log.push_back(cyc); end
      if (w_hs)  begin s_w_cnt++; w_log.push_back(cyc); end
      if (r_hs) begin
        if (s_ar_q.size() > 0) s_ar_q.delete(0);
        r_hold = 1'b0; n_r_hs++;
      end else r_hold = r_valid_i;
      if (b_hs) begin
        if (s_aw_q.size() > 0) s_aw_q.delete(0);
        s_w_cnt--; b_hold = 1'b0; n_b_hs++;
      end else b_hold = b_valid_i;
      // model bookkeeping
      if (ar_hs && rd_iss_q.size() > 0) rd_iss_q.delete(0);
      if (aw_hs && aw_iss_q.size() > 0) aw_iss_q.delete(0);
      if (w_hs && w_iss_q.size() > 0) w_iss_q.delete(0);
      nxt_rv = 1'b0; nxt_rdata = exp_rdata; nxt_err = 1'b0;
      if ((r_hs || b_hs) && rsp_q.size() > 0) begin
        t = rsp_q.pop_front();
        nxt_rv    = 1'b1;
        nxt_rdata = t.we ? 32'h0 : rdata_fn(t.addr);
        nxt_err   = resp_fn(t.addr) >= 2'b10;
      end
      if (g_hs && mq.size() > 0) begin
        t = mq.pop_front();
        rsp_q.push_back(t);
        if (t.we) begin aw_iss_q.push_back(t); w_iss_q.push_back(t); end
        else rd_iss_q.push_back(t.addr);
        req_held = 1'b0;
        gnt_log.push_back(cyc);
      end
      outstanding = outstanding + (g_hs ? 1 : 0) - (exp_rv ? 1 : 0);
      if (obi_rvalid_o) begin
        rv_log.push_back(cyc); rvd_log.push_back(obi_rdata_o); rve_log.push_back(obi_err_o);
      end
      exp_rv = nxt_rv; exp_rdata = nxt_rdata; exp_err = nxt_err;
    end else begin
      rsp_q.delete(); rd_iss_q.delete(); aw_iss_q.delete(); w_iss_q.delete();
      outstanding = 0; exp_rv = 1'b0; exp_rdata = '0; req_held = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int i;
    ar_pct = 100; aw_pct = 100; w_pct = 100; r_pct = 100; b_pct = 100; req_pct = 100;
    i = 0;
    while (i < 2000 && !(mq.size() == 0 && rsp_q.size() == 0 && !exp_rv)) begin
      cycle();
      i++;
    end
    chk({tag, "_drain_timeout"}, i >= 2000, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"}, obi_gnt_o, 0);
    chk({tag, "_rvalid"}, obi_rvalid_o, 0);
    chk({tag, "_err"}, obi_err_o, 0);
    chk({tag, "_rdata"}, obi_rdata_o, 0);
    chk({tag, "_ar_valid"}, ar_valid_o, 0);
    chk({tag, "_aw_valid"}, aw_valid_o, 0);
    chk({tag, "_w_valid"}, w_valid_o, 0);
    chk({tag, "_r_ready"}, r_ready_o, 0);
    chk({tag, "_b_ready"}, b_ready_o, 0);
    chk({tag, "_addr"}, {ar_addr_o, aw_addr_o}, 0);
    chk({tag, "_wdata"}, {w_strb_o, w_data_o}, 0);
  endtask

  initial begin
    int g0, base, base_r;
    txn_t t;
    obi_req_i = 0; obi_we_i = 0; obi_addr_i = '0; obi_be_i = '0; obi_wdata_i = '0;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 0; b_resp_i = '0; r_valid_i = 0; r_data_i = '0; r_resp_i = '0;
    rst = 1'b1;
    #1;
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    check_idle("reset");

    // single read, zero wait, same-cycle R
    clear_logs();
    mq.push_back(mk(1'b0, 32'h0001_0004, 4'hF, 32'h0));
    drain("t1");
    g0 = (gnt_log.size() > 0) ? gnt_log[0] : -100;
    chk("t1_ar_lat", (ar_log.size() > 0) ? ar_log[0] - g0 : -1, 1);
    chk("t1_rv_lat", (rv_log.size() > 0) ? rv_log[0] - g0 : -1, 2);
    chk("t1_rdata", (rvd_log.size() > 0) ? rvd_log[0] : 0, 32'hDEAD_BEEF);
    chk("t1_err", (rve_log.size() > 0) ? rve_log[0] : 1'bx, 1'b0);

    // write with AW ready delayed 3 cycles, followed by a second write
    clear_logs();
    mq.push_back(mk(1'b1, 32'h1000_0008, 4'b0011, 32'h1234_5678));
    mq.push_back(mk(1'b1, 32'h1000_0010, 4'hF, 32'hCAFE_0001));
    base = cyc;
    for (int i = 0; i < 14; i++) begin
      aw_pct = (i >= 4) ? 100 : 0;
      cycle();
    end
    drain("t2");
    g0 = (gnt_log.size() > 0) ? gnt_log[0] : -100;
    chk("t2_gnt0", g0 - base, 0);
    chk("t2_w_lat", (w_log.size() > 0) ? w_log[0] - g0 : -1, 1);
    chk("t2_aw_lat", (aw_log.size() > 0) ? aw_log[0] - g0 : -1, 4);
    chk("t2_gnt1", (gnt_log.size() > 1) ? gnt_log[1] - g0 : -1, 4);
    chk("t2_rdata", (rvd_log.size() > 0) ? rvd_log[0] : 32'hFFFF_FFFF, 0);
    chk("t2_err", (rve_log.size() > 0) ? rve_log[0] : 1'bx, 1'b0);

    // six back-to-back reads, R stalled: fills at MAX_OUTSTANDING
    clear_logs();
    for (int i = 0; i < 6; i++) mq.push_back(mk(1'b0, 32'h0000_4000 + 32'(i * 4), 4'hF, 0));
    r_pct = 0;
    repeat (10) cycle();
    chk("t3_full_grants", gnt_log.size(), MAXO);
    chk("t3_b2b", (gnt_log.size() >= 4) ? gnt_log[3] - gnt_log[0] : -1, 3);
    drain("t3");
    chk("t3_all_grants", gnt_log.size(), 6);
    chk("t3_all_rvalid", rv_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rvd_log.size()) chk("t3_order", rvd_log[i], rdata_fn(32'h0000_4000 + 32'(i * 4)));

    // read A, write B, read C with B response offered before R(A)
    clear_logs();
    base = n_b_hs;
    mq.push_back(mk(1'b0, 32'h0000_0100, 4'hF, 0));
    mq.push_back(mk(1'b1, 32'h0000_0200, 4'hF, 32'h5555_AAAA));
    mq.push_back(mk(1'b0, 32'h0000_0300, 4'hF, 0));
    r_pct = 0;
    repeat (8) cycle();
    chk("t4_b_held", n_b_hs - base, 0);
    drain("t4");
    chk("t4_n", rvd_log.size(), 3);
    if (rvd_log.size() == 3) begin
      chk("t4_A", rvd_log[0], rdata_fn(32'h0000_0100));
      chk("t4_B", rvd_log[1], 0);
      chk("t4_C", rvd_log[2], rdata_fn(32'h0000_0300));
    end

    // error responses then OKAY
    clear_logs();
    mq.push_back(mk(1'b0, 32'h0000_2000, 4'hF, 0));
    mq.push_back(mk(1'b1, 32'h0000_3000, 4'hF, 32'h1));
    mq.push_back(mk(1'b0, 32'h0000_0004, 4'hF, 0));
    drain("t5");
    chk("t5_n", rve_log.size(), 3);
    if (rve_log.size() == 3) begin
      chk("t5_rd_slverr", rve_log[0], 1'b1);
      chk("t5_wr_decerr", rve_log[1], 1'b1);
      chk("t5_okay", rve_log[2], 1'b0);
    end

    // reset with three outstanding and an AR pending
    clear_logs();
    for (int i = 0; i < 3; i++) mq.push_back(mk(1'b0, 32'h0000_0800 + 32'(i * 4), 4'hF, 0));
    r_pct = 0;
    for (int i = 0; i < 8; i++) begin
      ar_pct = (ar_log.size() >= 2) ? 0 : 100;
      cycle();
    end
    chk("t6_pre_out", outstanding, 3);
    chk("t6_pre_ar", ar_valid_o, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check_idle("t6_rst");
    base_r = n_r_hs;
    r_pct = 100; ar_pct = 100;
    repeat (3) cycle();
    chk("t6_late_r", n_r_hs - base_r, 0);
    s_ar_q.delete(); s_aw_q.delete(); s_w_cnt = 0;
    r_hold = 1'b0; b_hold = 1'b0; r_valid_i = 1'b0; b_valid_i = 1'b0;
    clear_logs();
    mq.push_back(mk(1'b0, 32'h0001_0004, 4'hF, 0));
    drain("t6_fresh");
    chk("t6_fresh_rdata", (rvd_log.size() > 0) ? rvd_log[0] : 0, 32'hDEAD_BEEF);
    clear_logs();
    for (int i = 0; i < MAXO + 1; i++) mq.push_back(mk(1'b0, 32'h0000_0A00 + 32'(i * 4), 4'hF, 0));
    r_pct = 0;
    repeat (10) cycle();
    chk("t6_count_restart", gnt_log.size(), MAXO);
    drain("t6_refill");

    // randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      req_pct = $urandom_range(100, 30);
      ar_pct  = $urandom_range(100, 20);
      aw_pct  = $urandom_range(100, 20);
      w_pct   = $urandom_range(100, 20);
      r_pct   = $urandom_range(100, 20);
      b_pct   = $urandom_range(100, 20);
      for (int i = 0; i < 40; i++) begin
        t.we = $urandom_range(1); t.addr = $urandom & 32'hFFFF_FFFC;
        t.be = 4'($urandom_range(15)); t.wdata = $urandom;
        mq.push_back(t);
      end
      repeat (150) cycle();
    end
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
